rob_multiport: RTL and testbench
================================

// Module: rob_multiport
// PURPOSE
//  Parametrised reorder buffer for the OoO core: circular queue of in-flight instructions.
//  Allocates up to DISPATCH_W entries per cycle from rename/dispatch and records completions from CMPL_PORTS FUs (alu1, alu2, mem).
//  Retires up to RETIRE_W oldest completed entries in program order; retire returns rd_old to the rename free pool.
//  A full flush clears all state in one cycle.
// PARAMETERS
//  DEPTH       16  entries; power of two; IDX_W = $clog2(DEPTH) (=ROB_SIZE_BITS at default)
//  DISPATCH_W  2   dispatch lanes per cycle
//  RETIRE_W    2   max retirements per cycle
//  CMPL_PORTS  3   completion ports (alu1, alu2, mem)
// PORTS
//  clk           in   1                clock
//  reset_n       in   1                synchronous, active-low reset
//  flush         in   1                discard all in-flight entries
//  disp_valid    in   DISPATCH_W       lane valid; lanes contiguous from lane 0
//  disp_rd       in   DISPATCH_W*6     physical dest
//  disp_rd_old   in   DISPATCH_W*6     previous physical mapping of arch rd
//  disp_pc       in   DISPATCH_W*32    instruction PC
//  disp_regwr    in   DISPATCH_W       RegWrite control
//  disp_ready    out  1                free entries >= DISPATCH_W
//  disp_robnum   out  DISPATCH_W*IDX_W tag assigned to each lane (tail+k)
//  cmpl_valid    in   CMPL_PORTS       completion strobe
//  cmpl_robnum   in   CMPL_PORTS*IDX_W tag being completed
//  cmpl_result   in   CMPL_PORTS*32    result value
//  ret_valid     out  RETIRE_W         retire lane valid; contiguous from lane 0
//  ret_rd        out  RETIRE_W*6       committed physical dest
//  ret_rd_old    out  RETIRE_W*6       register returned to free pool
//  ret_regwr     out  RETIRE_W         RegWrite of retiring entry
//  ret_result    out  RETIRE_W*32      committed value
//  ret_pc        out  RETIRE_W*32      committed PC
//  count         out  IDX_W+1          occupied entries
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): head=tail=0, count=0, every entry valid=0/complete=0.
//    All outputs 0 except disp_ready=1 and disp_robnum={k}.
//  - Pointers: IDX_W+1 bits, MSB is wrap bit. empty: head==tail. full: IDX equal, MSBs differ. Index wraps modulo DEPTH.
//  - Dispatch: accepted at edge when disp_ready & |disp_valid. Lane k writes entry tail+k (valid=1, complete=0).
//    tail += popcount(disp_valid). disp_ready uses current count only; no same-cycle credit from retire.
//    A non-contiguous disp_valid is illegal; assertion fires.
//  - Completion: each port sets complete=1 and stores result at its robnum on the edge.
//    Completion to an entry with valid=0 is ignored. Two ports with the same robnum is illegal; assertion fires.
//    Ports are applied in index order; the highest index wins.
//  - Retire (combinational from registered state): lane j valid iff entries head..head+j are all valid&complete.
//    Stops at the first incomplete entry. ret_* fields are taken from entry head+j.
//    At the edge: the retired entries are cleared and head += popcount(ret_valid).
//  - Latency: dispatch->earliest completion visible next cycle; completion->earliest retire one cycle later.
//    A DEPTH=16 ROB with both lanes retiring drains in 8 cycles.
//  - Simultaneous events: dispatch, completion and retire in one cycle all take effect.
//    count_next = count + ndisp - nret. A slot freed by retire is reused no earlier than next cycle.
//  - Flush: priority over everything; ret_valid forced 0 in the flush cycle.
//    At the edge: all valid/complete cleared, head=tail=0, count=0; dispatch and completions that cycle are dropped.
//  - Reset mid-operation behaves identically to flush and additionally zeroes stored payloads.
//  - Overflow/underflow impossible by construction; an assertion checks count<=DEPTH.
// STRUCTURE
//  - typedefs package: add ROB_DEPTH/ROB_IDX_W localparams tied to ROB_SIZE_BITS.
//    Reuse robEntryStruct for storage; add robCmplStruct {valid, robNum, result} and robRetireStruct {valid, rd, rd_old, regwr, result, pc}.
//  - One sub-module: rob_retire_select, a combinational RETIRE_W-deep prefix scan from head producing ret_valid and nret.
//  - Entry array is flops (DEPTH x entry); no SRAM.
// TESTING
//  1. Reset then idle: count=0, disp_ready=1, disp_robnum={1,0}, ret_valid=0.
//  2. Dispatch 2/cycle for 8 cycles, no completions -> count=16, disp_ready=0.
//     A 9th dispatch is not accepted and tail is unchanged.
//  3. Fill with tags 0..3, complete 3,2,1 out of order -> no retire.
//     Then complete 0 -> next cycle ret_valid=2'b11 (tags 0,1); following cycle tags 2,3.
//  4. Wrap: head=14, dispatch 4 -> tags 14,15,0,1. Complete all -> retire 14,15 then 0,1; count back to 0.
//  5. Same cycle: full ROB with head complete, dispatch 2, retire 2 -> disp_ready=0 that cycle, so no dispatch.
//     Next cycle disp_ready=1 and tags reuse freed slots.
//  6. Flush with 5 in-flight plus a completion and a dispatch in the same cycle -> ret_valid=0 that cycle.
//     Next cycle count=0 and head=tail=0. Repeat with reset_n=0 mid-stream -> same result.

Source files
------------

// File: rtl/rob_multiport_pkg.sv
// Shared types and sizing for the reorder buffer: entry storage, completion and retire records.
package rob_multiport_pkg;

  localparam int ROB_SIZE_BITS = 4;
  localparam int ROB_DEPTH     = 1 << ROB_SIZE_BITS;
  localparam int ROB_IDX_W     = ROB_SIZE_BITS;

  typedef struct packed {
    logic        valid;
    logic        complete;
    logic        regwr;
    logic [5:0]  rd;
    logic [5:0]  rd_old;
    logic [31:0] pc;
    logic [31:0] result;
  } robEntryStruct;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] robNum;
    logic [31:0]          result;
  } robCmplStruct;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rd;
    logic [5:0]  rd_old;
    logic        regwr;
    logic [31:0] result;
    logic [31:0] pc;
  } robRetireStruct;

endpackage

// File: rtl/rob_multiport_retire_select.sv
// In-order retire prefix scan: lane j retires only if every entry from head through head+j is ready.
module rob_retire_select #(
  parameter int RETIRE_W = 2,
  parameter int NR_W     = $clog2(RETIRE_W + 1)
) (
  input  logic [RETIRE_W-1:0] ready,
  input  logic                kill,
  output logic [RETIRE_W-1:0] ret_valid,
  output logic [NR_W-1:0]     nret
);

  logic run;

  always_comb begin
    run       = ~kill;
    ret_valid = '0;
    nret      = '0;
    for (int j = 0; j < RETIRE_W; j++) begin
      run          = run & ready[j];
      ret_valid[j] = run;
      nret         = nret + NR_W'(run);
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: circular queue with wide dispatch, per-FU completion and in-order retire.
module rob_multiport
  import rob_multiport_pkg::*;
#(
  parameter int DEPTH      = ROB_DEPTH,
  parameter int DISPATCH_W = 2,
  parameter int RETIRE_W   = 2,
  parameter int CMPL_PORTS = 3,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [DISPATCH_W-1:0]        disp_valid,
  input  logic [DISPATCH_W*6-1:0]      disp_rd,
  input  logic [DISPATCH_W*6-1:0]      disp_rd_old,
  input  logic [DISPATCH_W*32-1:0]     disp_pc,
  input  logic [DISPATCH_W-1:0]        disp_regwr,
  output logic                         disp_ready,
  output logic [DISPATCH_W*IDX_W-1:0]  disp_robnum,
  input  logic [CMPL_PORTS-1:0]        cmpl_valid,
  input  logic [CMPL_PORTS*IDX_W-1:0]  cmpl_robnum,
  input  logic [CMPL_PORTS*32-1:0]     cmpl_result,
  output logic [RETIRE_W-1:0]          ret_valid,
  output logic [RETIRE_W*6-1:0]        ret_rd,
  output logic [RETIRE_W*6-1:0]        ret_rd_old,
  output logic [RETIRE_W-1:0]          ret_regwr,
  output logic [RETIRE_W*32-1:0]       ret_result,
  output logic [RETIRE_W*32-1:0]       ret_pc,
  output logic [IDX_W:0]               count
);

  localparam int PTR_W = IDX_W + 1;
  localparam int NR_W  = $clog2(RETIRE_W + 1);

  robEntryStruct     entries [DEPTH];
  robRetireStruct    lanes   [RETIRE_W];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W-1:0]  ndisp;
  logic [RETIRE_W-1:0] ready;
  logic [NR_W-1:0]   nret;
  logic              accept;

  function automatic logic [IDX_W-1:0] slot(input logic [PTR_W-1:0] ptr, input int off);
    return ptr[IDX_W-1:0] + IDX_W'(off);
  endfunction

  function automatic logic [PTR_W-1:0] popcount(input logic [DISPATCH_W-1:0] v);
    logic [PTR_W-1:0] n;
    n = '0;
    for (int k = 0; k < DISPATCH_W; k++) n = n + PTR_W'(v[k]);
    return n;
  endfunction

  // Pointer difference is exact because the wrap bit distinguishes full from empty.
  assign count      = tail - head;
  assign disp_ready = (PTR_W'(DEPTH) - count) >= PTR_W'(DISPATCH_W);
  assign accept     = disp_ready & (|disp_valid);
  assign ndisp      = accept ? popcount(disp_valid) : '0;

  always_comb begin
    disp_robnum = '0;
    for (int k = 0; k < DISPATCH_W; k++) disp_robnum[k*IDX_W +: IDX_W] = slot(tail, k);
  end

  always_comb begin
    ready = '0;
    for (int j = 0; j < RETIRE_W; j++)
      ready[j] = entries[slot(head, j)].valid & entries[slot(head, j)].complete;
  end

  rob_retire_select #(
    .RETIRE_W (RETIRE_W),
    .NR_W     (NR_W)
  ) u_retire_select (
    .ready     (ready),
    .kill      (flush | ~reset_n),
    .ret_valid (ret_valid),
    .nret      (nret)
  );

  // Payload fields are driven to zero on idle lanes so stale entries never leak out.
  always_comb begin
    ret_rd     = '0;
    ret_rd_old = '0;
    ret_regwr  = '0;
    ret_result = '0;
    ret_pc     = '0;
    for (int j = 0; j < RETIRE_W; j++) begin
      lanes[j] = '{valid:  ret_valid[j],
                   rd:     entries[slot(head, j)].rd,
                   rd_old: entries[slot(head, j)].rd_old,
                   regwr:  entries[slot(head, j)].regwr,
                   result: entries[slot(head, j)].result,
                   pc:     entries[slot(head, j)].pc};
      if (lanes[j].valid) begin
        ret_rd[j*6 +: 6]       = lanes[j].rd;
        ret_rd_old[j*6 +: 6]   = lanes[j].rd_old;
        ret_regwr[j]           = lanes[j].regwr;
        ret_result[j*32 +: 32] = lanes[j].result;
        ret_pc[j*32 +: 32]     = lanes[j].pc;
      end
    end
  end

  // Completions first, then retire clears, then dispatch writes: later writes win per entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid    <= 1'b0;
        entries[i].complete <= 1'b0;
      end
    end else begin
      for (int p = 0; p < CMPL_PORTS; p++) begin
        if (cmpl_valid[p] && entries[cmpl_robnum[p*IDX_W +: IDX_W]].valid) begin
          entries[cmpl_robnum[p*IDX_W +: IDX_W]].complete <= 1'b1;
          entries[cmpl_robnum[p*IDX_W +: IDX_W]].result   <= cmpl_result[p*32 +: 32];
        end
      end
      for (int j = 0; j < RETIRE_W; j++) begin
        if (ret_valid[j]) begin
          entries[slot(head, j)].valid    <= 1'b0;
          entries[slot(head, j)].complete <= 1'b0;
        end
      end
      for (int k = 0; k < DISPATCH_W; k++) begin
        if (accept && disp_valid[k])
          entries[slot(tail, k)] <= '{valid:    1'b1,
                                      complete: 1'b0,
                                      regwr:    disp_regwr[k],
                                      rd:       disp_rd[k*6 +: 6],
                                      rd_old:   disp_rd_old[k*6 +: 6],
                                      pc:       disp_pc[k*32 +: 32],
                                      result:   32'd0};
      end
      head <= head + PTR_W'(nret);
      tail <= tail + ndisp;
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      assert ((disp_valid & (disp_valid + DISPATCH_W'(1))) == '0);
      assert (count <= PTR_W'(DEPTH));
      for (int p = 0; p < CMPL_PORTS; p++)
        for (int q = p + 1; q < CMPL_PORTS; q++)
          assert (!(cmpl_valid[p] && cmpl_valid[q] &&
                    cmpl_robnum[p*IDX_W +: IDX_W] == cmpl_robnum[q*IDX_W +: IDX_W]));
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: queue-based reference model checked every cycle, directed scenarios plus random traffic.
module tb_rob_multiport;

  logic        clk;
  logic        reset_n, flush;
  logic [1:0]  disp_valid, disp_regwr;
  logic [11:0] disp_rd, disp_rd_old;
  logic [63:0] disp_pc;
  logic        disp_ready;
  logic [7:0]  disp_robnum;
  logic [2:0]  cmpl_valid;
  logic [11:0] cmpl_robnum;
  logic [95:0] cmpl_result;
  logic [1:0]  ret_valid, ret_regwr;
  logic [11:0] ret_rd, ret_rd_old;
  logic [63:0] ret_result, ret_pc;
  logic [4:0]  count;

  rob_multiport dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_rd_old(disp_rd_old),
    .disp_pc(disp_pc), .disp_regwr(disp_regwr), .disp_ready(disp_ready),
    .disp_robnum(disp_robnum), .cmpl_valid(cmpl_valid), .cmpl_robnum(cmpl_robnum),
    .cmpl_result(cmpl_result), .ret_valid(ret_valid), .ret_rd(ret_rd),
    .ret_rd_old(ret_rd_old), .ret_regwr(ret_regwr), .ret_result(ret_result),
    .ret_pc(ret_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program-ordered queue of in-flight instructions; element i carries tag (mhead+i)%16.
  typedef struct {
    logic [5:0]  rd, rd_old;
    logic        regwr;
    logic [31:0] pc, result;
    bit          done;
  } ment_t;

  ment_t q[$];
  int    mhead   = 0;
  int    seq     = 0;
  int    nchk    = 0;
  int    npass   = 0;
  bit    started = 0;
  bit    rnd     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_nret();
    int n = 0;
    if (flush || !reset_n) return 0;
    while (n < 2 && n < q.size() && q[n].done) n++;
    return n;
  endfunction

  task automatic check_outputs();
    int n, sz, mt;
    logic [1:0]  e_rv, e_rw;
    logic [11:0] e_rd, e_ro;
    logic [63:0] e_res, e_pc;
    n  = model_nret();
    sz = q.size();
    mt = (mhead + sz) % 16;
    e_rv = '0; e_rw = '0; e_rd = '0; e_ro = '0; e_res = '0; e_pc = '0;
    for (int j = 0; j < n; j++) begin
      e_rv[j]           = 1'b1;
      e_rw[j]           = q[j].regwr;
      e_rd[j*6 +: 6]    = q[j].rd;
      e_ro[j*6 +: 6]    = q[j].rd_old;
      e_res[j*32 +: 32] = q[j].result;
      e_pc[j*32 +: 32]  = q[j].pc;
    end
    chk("count", 64'(count), 64'(sz));
    chk("disp_ready", 64'(disp_ready), 64'((16 - sz) >= 2));
    chk("disp_robnum", 64'(disp_robnum), 64'({4'((mt + 1) % 16), 4'(mt)}));
    chk("ret_valid", 64'(ret_valid), 64'(e_rv));
    chk("ret_rd", 64'(ret_rd), 64'(e_rd));
    chk("ret_rd_old", 64'(ret_rd_old), 64'(e_ro));
    chk("ret_regwr", 64'(ret_regwr), 64'(e_rw));
    chk("ret_result", ret_result, e_res);
    chk("ret_pc", ret_pc, e_pc);
  endtask

  task automatic model_update();
    int nr, off;
    bit room;
    ment_t e;
    if (!reset_n || flush) begin
      q.delete();
      mhead = 0;
      return;
    end
    nr   = model_nret();
    room = (16 - q.size()) >= 2;
    for (int p = 0; p < 3; p++) begin
      if (cmpl_valid[p]) begin
        off = (int'(cmpl_robnum[p*4 +: 4]) - mhead + 16) % 16;
        if (off < q.size()) begin
          q[off].done   = 1;
          q[off].result = cmpl_result[p*32 +: 32];
        end
      end
    end
    for (int j = 0; j < nr; j++) void'(q.pop_front());
    mhead = (mhead + nr) % 16;
    if (room) begin
      for (int k = 0; k < 2; k++) begin
        if (disp_valid[k]) begin
          e.rd     = disp_rd[k*6 +: 6];
          e.rd_old = disp_rd_old[k*6 +: 6];
          e.regwr  = disp_regwr[k];
          e.pc     = disp_pc[k*32 +: 32];
          e.result = '0;
          e.done   = 0;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic drive(input logic rn, input logic fl, input logic [1:0] dv,
                       input logic [2:0] cv, input logic [3:0] t0, t1, t2);
    reset_n    = rn;
    flush      = fl;
    disp_valid = dv;
    for (int k = 0; k < 2; k++) begin
      disp_rd[k*6 +: 6]     = rnd ? 6'($urandom) : 6'(seq + k);
      disp_rd_old[k*6 +: 6] = rnd ? 6'($urandom) : 6'(seq + k + 32);
      disp_regwr[k]         = rnd ? 1'($urandom) : 1'(((seq + k) % 3) != 0);
      disp_pc[k*32 +: 32]   = 32'h100 + 32'((seq + k) * 4);
    end
    cmpl_valid  = cv;
    cmpl_robnum = {t2, t1, t0};
    for (int p = 0; p < 3; p++)
      cmpl_result[p*32 +: 32] = rnd ? $urandom : (32'hC000_0000 | 32'(cmpl_robnum[p*4 +: 4]));
    #1;
    if (started) check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    if (disp_valid != 2'b00) seq += 2;
    started = 1;
    #1;
  endtask

  task automatic cyc(input logic rn, input logic fl, input logic [1:0] dv,
                     input logic [2:0] cv, input logic [3:0] t0, t1, t2);
    drive(rn, fl, dv, cv, t0, t1, t2);
    tick();
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 2'b00, 3'b000, 4'd0, 4'd0, 4'd0);
  endtask

  logic       r_rn, r_fl;
  logic [1:0] r_dv;
  logic [2:0] r_cv;
  logic [3:0] r_t [3];

  initial begin
    reset_n = 1'b0; flush = 1'b0; disp_valid = '0; disp_regwr = '0;
    disp_rd = '0; disp_rd_old = '0; disp_pc = '0;
    cmpl_valid = '0; cmpl_robnum = '0; cmpl_result = '0;
    @(negedge clk);

    // Reset then idle
    cyc(1'b0, 1'b0, 2'b00, 3'b000, 0, 0, 0);
    cyc(1'b0, 1'b0, 2'b00, 3'b000, 0, 0, 0);
    idle();
    chk("lit_reset_count", 64'(count), 64'd0);
    chk("lit_reset_ready", 64'(disp_ready), 64'd1);
    chk("lit_reset_robnum", 64'(disp_robnum), 64'h10);
    chk("lit_reset_retv", 64'(ret_valid), 64'd0);
    tick();

    // Fill to full, then a refused dispatch
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
    idle();
    chk("lit_full_count", 64'(count), 64'd16);
    chk("lit_full_ready", 64'(disp_ready), 64'd0);
    tick();
    cyc(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
    idle();
    chk("lit_ninth_count", 64'(count), 64'd16);
    chk("lit_ninth_robnum", 64'(disp_robnum), 64'h10);
    tick();

    // Out-of-order completion, in-order retire
    cyc(1'b0, 1'b0, 2'b00, 3'b000, 0, 0, 0);
    seq = 0;
    cyc(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
    cyc(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
    cyc(1'b1, 1'b0, 2'b00, 3'b111, 4'd3, 4'd2, 4'd1);
    idle();
    chk("lit_ooo_noret", 64'(ret_valid), 64'd0);
    tick();
    cyc(1'b1, 1'b0, 2'b00, 3'b001, 4'd0, 0, 0);
    idle();
    chk("lit_ooo_ret01_v", 64'(ret_valid), 64'd3);
    chk("lit_ooo_ret01_pc", ret_pc, {32'h104, 32'h100});
    tick();
    idle();
    chk("lit_ooo_ret23_v", 64'(ret_valid), 64'd3);
    chk("lit_ooo_ret23_pc", ret_pc, {32'h10C, 32'h108});
    tick();
    idle();
    chk("lit_ooo_empty", 64'(count), 64'd0);
    tick();

    // Wrap around the end of the buffer
    cyc(1'b0, 1'b0, 2'b00, 3'b000, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 2'b00, 3'b001, 4'(i), 0, 0);
    cyc(1'b1, 1'b0, 2'b00, 3'b000, 0, 0, 0);
    idle();
    chk("lit_wrap_head14", 64'(disp_robnum), 64'hFE);
    chk("lit_wrap_count0", 64'(count), 64'd0);
    tick();
    cyc(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
    cyc(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
    cyc(1'b1, 1'b0, 2'b00, 3'b111, 4'd14, 4'd15, 4'd0);
    cyc(1'b1, 1'b0, 2'b00, 3'b001, 4'd1, 0, 0);
    cyc(1'b1, 1'b0, 2'b00, 3'b000, 0, 0, 0);
    idle();
    chk("lit_wrap_drained", 64'(count), 64'd0);
    chk("lit_wrap_tail", 64'(disp_robnum), 64'h32);
    tick();

    // Full buffer: retire and refused dispatch in the same cycle
    cyc(1'b0, 1'b0, 2'b00, 3'b000, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
    cyc(1'b1, 1'b0, 2'b00, 3'b011, 4'd0, 4'd1, 0);
    drive(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
    chk("lit_same_ready0", 64'(disp_ready), 64'd0);
    chk("lit_same_retv", 64'(ret_valid), 64'd3);
    tick();
    idle();
    chk("lit_same_count14", 64'(count), 64'd14);
    chk("lit_same_ready1", 64'(disp_ready), 64'd1);
    chk("lit_same_reuse", 64'(disp_robnum), 64'h10);
    tick();

    // Flush and mid-stream reset with concurrent dispatch and completion
    for (int r = 0; r < 2; r++) begin
      cyc(1'b0, 1'b0, 2'b00, 3'b000, 0, 0, 0);
      cyc(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
      cyc(1'b1, 1'b0, 2'b11, 3'b000, 0, 0, 0);
      cyc(1'b1, 1'b0, 2'b01, 3'b000, 0, 0, 0);
      cyc(1'b1, 1'b0, 2'b00, 3'b001, 4'd0, 0, 0);
      drive(r == 0, r == 1 ? 1'b0 : 1'b1, 2'b11, 3'b010, 0, 4'd2, 0);
      chk("lit_kill_retv", 64'(ret_valid), 64'd0);
      tick();
      idle();
      chk("lit_kill_count", 64'(count), 64'd0);
      chk("lit_kill_ptrs", 64'(disp_robnum), 64'h10);
      tick();
    end

    // Random traffic
    rnd = 1;
    for (int it = 0; it < 3000; it++) begin
      r_rn = ($urandom_range(0, 99) != 0);
      r_fl = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 2))
        0:       r_dv = 2'b00;
        1:       r_dv = 2'b01;
        default: r_dv = 2'b11;
      endcase
      for (int p = 0; p < 3; p++) begin
        r_cv[p] = ($urandom_range(0, 99) < 40);
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          r_t[p] = 4'((mhead + int'($urandom_range(0, q.size() - 1))) % 16);
        else
          r_t[p] = 4'($urandom_range(0, 15));
      end
      for (int p = 1; p < 3; p++)
        for (int s = 0; s < p; s++)
          if (r_cv[s] && r_cv[p] && r_t[s] == r_t[p]) r_cv[p] = 1'b0;
      cyc(r_rn, r_fl, r_dv, r_cv, r_t[0], r_t[1], r_t[2]);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
